mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Parameters
REQ-001 SHALL have parameter BITSIZE, default 32, meaning the width of addresses and data.
REQ-002 SHALL have parameter MAX_STREAK, default 4, meaning the maximum number of consecutive MEM grants while IF waits.

Interface
REQ-003 clk  in  1  single clock; all registers on posedge.
REQ-004 reset_i  in  1  reset, asynchronous, active-high.
REQ-005 if_req_i  in  1  fetch request; level, held with if_addr_i stable until if_ack_o.
REQ-006 if_addr_i  in  BITSIZE  fetch address.
REQ-007 if_flush_i  in  1  branch redirect; kills a pending or in-flight fetch.
REQ-008 if_ack_o  out  1  one-cycle fetch completion pulse.
REQ-009 if_rdata_o  out  BITSIZE  fetched word; held until the next if_ack_o.
REQ-010 mem_req_i  in  1  load/store request; level, held with its attributes stable until mem_ack_o.
REQ-011 mem_we_i  in  1  1 = store, 0 = load.
REQ-012 mem_be_i  in  4  byte enables.
REQ-013 mem_addr_i  in  BITSIZE  load/store address.
REQ-014 mem_wdata_i  in  BITSIZE  store data.
REQ-015 mem_ack_o  out  1  one-cycle load/store completion pulse.
REQ-016 mem_rdata_o  out  BITSIZE  load data; held until the next load ack.
REQ-017 bus_req_o, bus_we_o, bus_be_o[3:0], bus_addr_o, bus_wdata_o  out  shared memory port, registered.
REQ-018 bus_ready_i  in  1  memory completes the current access in this cycle.
REQ-019 bus_rdata_i  in  BITSIZE  read data, valid when bus_ready_i=1.

Function
REQ-020 The FSM SHALL have exactly four states: IDLE, BUSY_IF, BUSY_MEM and RESP.
REQ-021 In IDLE, if mem_req_i=1 and NOT (streak==MAX_STREAK and if_req_i=1 and if_flush_i=0), the FSM SHALL go to BUSY_MEM.
REQ-022 Otherwise in IDLE, if if_req_i=1 and if_flush_i=0, the FSM SHALL go to BUSY_IF; otherwise it SHALL stay in IDLE.
REQ-023 On every transition into BUSY_x, the registers SHALL capture the winner's attributes; IF accesses drive we=0 and be=4'hF.
REQ-024 bus_req_o SHALL be 1 in exactly the BUSY_* states.
REQ-025 Bus outputs SHALL stay stable while bus_req_o=1.
REQ-026 Minimum latency: request seen at edge 0 gives bus_req_o=1 in cycle 1.
REQ-027 In BUSY_x with bus_ready_i=1, the next edge SHALL go to RESP.
REQ-028 bus_ready_i SHALL be ignored in IDLE and RESP.
REQ-029 RESP SHALL last exactly one cycle, then return to IDLE.
REQ-030 x_ack_o SHALL be 1 only during RESP, for the completed requester.
REQ-031 The request of the requester acked in RESP SHALL NOT be sampled during RESP (no double grant).
REQ-032 mem_rdata_o / if_rdata_o SHALL capture bus_rdata_i at the completion edge.
REQ-033 On a store completion, mem_rdata_o SHALL keep its previous value.
REQ-034 If if_flush_i=1 in any cycle of BUSY_IF, a kill flag SHALL be set; the bus access still completes.
REQ-035 When the kill flag is set at completion, the FSM SHALL go to IDLE directly with no if_ack_o and no if_rdata_o update; the flag then clears.
REQ-036 If if_flush_i=1 in IDLE, if_req_i SHALL be ignored that cycle.
REQ-037 The streak counter SHALL increment, saturating at MAX_STREAK, on each MEM grant made while if_req_i=1.
REQ-038 The streak counter SHALL clear on an IF grant and on a MEM grant made with if_req_i=0.
REQ-039 When both requests arrive in the same IDLE cycle, MEM SHALL win unless the streak is saturated.
REQ-040 Width: addresses and data SHALL pass unmodified, with no arithmetic on them.

Reset
REQ-041 reset_i=1 SHALL immediately and asynchronously force state=IDLE, all outputs to 0, rdata registers to 0, streak=0 and kill=0.
REQ-042 A reset mid-access SHALL drop bus_req_o in the same cycle; no ack SHALL follow after release.
REQ-043 The first grant SHALL be possible at the first edge after reset_i deasserts.

Verification
REQ-044 Single load: mem_req_i=1, addr=0x100, we=0 at edge 0, bus_ready_i=1 with rdata=0xDEADBEEF in cycle 3 -> bus_req_o=1 in cycles 1-3, mem_ack_o=1 in cycle 4, mem_rdata_o=0xDEADBEEF, IDLE in cycle 5.
REQ-045 Simultaneous requests: if_req_i and mem_req_i both held, ready always 1, MAX_STREAK=4 -> grant order MEM,MEM,MEM,MEM,IF,MEM...; no back-to-back double grant of one ack.
REQ-046 Flush in flight: IF granted and if_flush_i pulsed in cycle 2, ready in cycle 4 -> no if_ack_o, if_rdata_o unchanged, FSM returns to IDLE in cycle 5.
REQ-047 Store: we=1, be=4'b0011, wdata=0x1234 -> the bus carries those values, mem_ack_o pulses, mem_rdata_o keeps its old value.
REQ-048 Reset mid-access: reset_i=1 in BUSY_MEM -> bus_req_o=0 in the same cycle, no mem_ack_o after release, and the request is re-granted at the first edge after release if still held.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates one shared memory port between instruction fetch (IF) and load/store (MEM).
// Grant takes one edge, the access holds until bus_ready_i, then a one-cycle RESP carries the ack.
module mem_arbiter #(
  parameter int BITSIZE    = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               if_req_i,
  input  logic [BITSIZE-1:0] if_addr_i,
  input  logic               if_flush_i,
  output logic               if_ack_o,
  output logic [BITSIZE-1:0] if_rdata_o,
  input  logic               mem_req_i,
  input  logic               mem_we_i,
  input  logic [3:0]         mem_be_i,
  input  logic [BITSIZE-1:0] mem_addr_i,
  input  logic [BITSIZE-1:0] mem_wdata_i,
  output logic               mem_ack_o,
  output logic [BITSIZE-1:0] mem_rdata_o,
  output logic               bus_req_o,
  output logic               bus_we_o,
  output logic [3:0]         bus_be_o,
  output logic [BITSIZE-1:0] bus_addr_o,
  output logic [BITSIZE-1:0] bus_wdata_o,
  input  logic               bus_ready_i,
  input  logic [BITSIZE-1:0] bus_rdata_i
);

  localparam int SW = $clog2(MAX_STREAK + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, RESP} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] streak;
  logic          kill;
  logic          resp_mem;
  logic          if_live;
  logic          if_dead;
  logic          streak_sat;
  logic          grant_mem, grant_if;

  assign if_live    = if_req_i && !if_flush_i;
  assign streak_sat = (streak == SW'(MAX_STREAK));
  // A flush seen in the completing cycle kills the fetch just like an earlier one.
  assign if_dead    = kill || if_flush_i;

  always_comb begin
    state_nxt = state;
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req_i && !(streak_sat && if_live)) begin
          state_nxt = BUSY_MEM;
          grant_mem = 1'b1;
        end else if (if_live) begin
          state_nxt = BUSY_IF;
          grant_if  = 1'b1;
        end
      end
      BUSY_IF: begin
        if (bus_ready_i) state_nxt = if_dead ? IDLE : RESP;
      end
      BUSY_MEM: begin
        if (bus_ready_i) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state       <= IDLE;
      streak      <= '0;
      kill        <= 1'b0;
      resp_mem    <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_be_o    <= 4'h0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      if_rdata_o  <= '0;
      mem_rdata_o <= '0;
    end else begin
      state <= state_nxt;

      if (grant_mem) begin
        bus_we_o    <= mem_we_i;
        bus_be_o    <= mem_be_i;
        bus_addr_o  <= mem_addr_i;
        bus_wdata_o <= mem_wdata_i;
        resp_mem    <= 1'b1;
        if (!if_req_i)       streak <= '0;
        else if (!streak_sat) streak <= streak + SW'(1);
      end

      if (grant_if) begin
        bus_we_o    <= 1'b0;
        bus_be_o    <= 4'hF;
        bus_addr_o  <= if_addr_i;
        bus_wdata_o <= '0;
        resp_mem    <= 1'b0;
        streak      <= '0;
      end

      // Kill persists until the in-flight fetch drains off the bus.
      if (state == BUSY_IF) kill <= bus_ready_i ? 1'b0 : if_dead;

      if (state == BUSY_IF && bus_ready_i && !if_dead) if_rdata_o <= bus_rdata_i;
      if (state == BUSY_MEM && bus_ready_i && !bus_we_o) mem_rdata_o <= bus_rdata_i;
    end
  end

  assign bus_req_o = (state == BUSY_IF) || (state == BUSY_MEM);
  assign if_ack_o  = (state == RESP) && !resp_mem;
  assign mem_ack_o = (state == RESP) && resp_mem;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios, then random traffic against a transaction model
// that owns a reference memory and predicts grants, acks and read data.
module tb_mem_arbiter;

  localparam int BW   = 32;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          if_req_i, if_flush_i, if_ack_o;
  logic [BW-1:0] if_addr_i, if_rdata_o;
  logic          mem_req_i, mem_we_i, mem_ack_o;
  logic [3:0]    mem_be_i;
  logic [BW-1:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
  logic          bus_req_o, bus_we_o, bus_ready_i;
  logic [3:0]    bus_be_o;
  logic [BW-1:0] bus_addr_o, bus_wdata_o, bus_rdata_i;

  int total = 0;
  int bad   = 0;

  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] ref_mem   [logic [31:0]];

  mem_arbiter #(.BITSIZE(BW), .MAX_STREAK(MAXS)) dut (
    .clk(clk), .reset_i(reset_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_be_i(mem_be_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_ack_o(mem_ack_o), .mem_rdata_o(mem_rdata_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_ready_i(bus_ready_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_default(logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] slave_read(logic [31:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : mem_default(a);
  endfunction

  function automatic logic [31:0] ref_read(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
  endfunction

  task automatic idle_inputs();
    if_req_i = 0; if_addr_i = '0; if_flush_i = 0;
    mem_req_i = 0; mem_we_i = 0; mem_be_i = 4'h0; mem_addr_i = '0; mem_wdata_i = '0;
    bus_ready_i = 0; bus_rdata_i = '0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    idle_inputs();
    @(negedge clk);
    total++; if ({bus_req_o, bus_we_o, bus_be_o} !== 6'h0) begin bad++; $display("FAIL rst_bus_ctl got=%h exp=0", {bus_req_o, bus_we_o, bus_be_o}); end
    total++; if (bus_addr_o !== '0) begin bad++; $display("FAIL rst_bus_addr got=%h exp=0", bus_addr_o); end
    total++; if (bus_wdata_o !== '0) begin bad++; $display("FAIL rst_bus_wdata got=%h exp=0", bus_wdata_o); end
    total++; if ({if_ack_o, mem_ack_o} !== 2'b00) begin bad++; $display("FAIL rst_acks got=%b exp=00", {if_ack_o, mem_ack_o}); end
    total++; if (if_rdata_o !== '0) begin bad++; $display("FAIL rst_if_rdata got=%h exp=0", if_rdata_o); end
    total++; if (mem_rdata_o !== '0) begin bad++; $display("FAIL rst_mem_rdata got=%h exp=0", mem_rdata_o); end
    reset_i = 1'b0;
  endtask

  task automatic test_single_load();
    mem_req_i = 1; mem_we_i = 0; mem_be_i = 4'hF; mem_addr_i = 32'h100;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      total++; if (bus_req_o !== 1'b1) begin bad++; $display("FAIL load_bus_req c%0d got=%b exp=1", c, bus_req_o); end
      total++; if (mem_ack_o !== 1'b0) begin bad++; $display("FAIL load_early_ack c%0d got=%b exp=0", c, mem_ack_o); end
      if (c == 3) begin bus_ready_i = 1; bus_rdata_i = 32'hDEADBEEF; end
    end
    total++; if ({bus_addr_o, bus_we_o} !== {32'h100, 1'b0}) begin bad++; $display("FAIL load_bus_attr got=%h/%b exp=100/0", bus_addr_o, bus_we_o); end
    @(negedge clk);
    total++; if (mem_ack_o !== 1'b1) begin bad++; $display("FAIL load_ack c4 got=%b exp=1", mem_ack_o); end
    total++; if (mem_rdata_o !== 32'hDEADBEEF) begin bad++; $display("FAIL load_rdata got=%h exp=deadbeef", mem_rdata_o); end
    total++; if (bus_req_o !== 1'b0) begin bad++; $display("FAIL load_resp_req got=%b exp=0", bus_req_o); end
    mem_req_i = 0; bus_ready_i = 0;
    @(negedge clk);
    total++; if ({bus_req_o, mem_ack_o} !== 2'b00) begin bad++; $display("FAIL load_idle c5 got=%b exp=00", {bus_req_o, mem_ack_o}); end
  endtask

  task automatic test_store();
    mem_req_i = 1; mem_we_i = 1; mem_be_i = 4'b0011; mem_addr_i = 32'h200; mem_wdata_i = 32'h1234;
    @(negedge clk);
    total++; if ({bus_req_o, bus_we_o, bus_be_o} !== 6'b1_1_0011) begin bad++; $display("FAIL store_bus_ctl got=%b exp=110011", {bus_req_o, bus_we_o, bus_be_o}); end
    total++; if ({bus_addr_o, bus_wdata_o} !== {32'h200, 32'h1234}) begin bad++; $display("FAIL store_bus_dat got=%h/%h exp=200/1234", bus_addr_o, bus_wdata_o); end
    bus_ready_i = 1; bus_rdata_i = 32'hBAD0BAD0;
    @(negedge clk);
    total++; if (mem_ack_o !== 1'b1) begin bad++; $display("FAIL store_ack got=%b exp=1", mem_ack_o); end
    total++; if (mem_rdata_o !== 32'hDEADBEEF) begin bad++; $display("FAIL store_rdata_kept got=%h exp=deadbeef", mem_rdata_o); end
    mem_req_i = 0; bus_ready_i = 0;
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    int got[$];
    int exp_order[6] = '{2, 2, 2, 2, 1, 2};
    logic prev_req = 1'b0, prev_if = 1'b0, prev_mem = 1'b0;
    int dbl = 0;
    if_req_i = 1; if_addr_i = 32'h4000;
    mem_req_i = 1; mem_we_i = 0; mem_be_i = 4'hF; mem_addr_i = 32'h8000;
    bus_ready_i = 1; bus_rdata_i = 32'h5151;
    for (int c = 0; c < 60 && got.size() < 6; c++) begin
      @(negedge clk);
      if (bus_req_o && !prev_req) got.push_back(bus_addr_o == 32'h4000 ? 1 : 2);
      if ((if_ack_o && prev_if) || (mem_ack_o && prev_mem)) dbl++;
      prev_req = bus_req_o; prev_if = if_ack_o; prev_mem = mem_ack_o;
    end
    if_req_i = 0;
    total++; if (got.size() != 6) begin bad++; $display("FAIL sim_grant_count got=%0d exp=6", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      total++; if (got[i] != exp_order[i]) begin bad++; $display("FAIL sim_order[%0d] got=%0d exp=%0d (1=IF 2=MEM)", i, got[i], exp_order[i]); end
    end
    for (int c = 0; c < 5 && !mem_ack_o; c++) @(negedge clk);
    total++; if (mem_ack_o !== 1'b1) begin bad++; $display("FAIL sim_last_ack got=%b exp=1", mem_ack_o); end
    total++; if (dbl != 0) begin bad++; $display("FAIL sim_double_ack got=%0d exp=0", dbl); end
    total++; if (if_rdata_o !== 32'h5151) begin bad++; $display("FAIL sim_if_rdata got=%h exp=5151", if_rdata_o); end
    mem_req_i = 0; bus_ready_i = 0;
    @(negedge clk);
  endtask

  task automatic test_flush();
    if_req_i = 1; if_addr_i = 32'h300;
    @(negedge clk);
    total++; if ({bus_req_o, bus_we_o, bus_be_o, bus_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h300}) begin bad++; $display("FAIL fl_bus_if got=%b%b%h/%h exp=10f/300", bus_req_o, bus_we_o, bus_be_o, bus_addr_o); end
    @(negedge clk);
    if_flush_i = 1; if_req_i = 0;
    @(negedge clk);
    if_flush_i = 0;
    total++; if (if_ack_o !== 1'b0) begin bad++; $display("FAIL fl_ack_c3 got=%b exp=0", if_ack_o); end
    @(negedge clk);
    total++; if (bus_req_o !== 1'b1) begin bad++; $display("FAIL fl_still_busy got=%b exp=1", bus_req_o); end
    bus_ready_i = 1; bus_rdata_i = 32'h55AA55AA;
    @(negedge clk);
    total++; if ({if_ack_o, bus_req_o} !== 2'b00) begin bad++; $display("FAIL fl_no_ack got=%b exp=00", {if_ack_o, bus_req_o}); end
    total++; if (if_rdata_o !== 32'h5151) begin bad++; $display("FAIL fl_rdata_kept got=%h exp=5151", if_rdata_o); end
    bus_ready_i = 0; if_req_i = 1; if_addr_i = 32'h304;
    @(negedge clk);
    total++; if ({bus_req_o, bus_addr_o} !== {1'b1, 32'h304}) begin bad++; $display("FAIL fl_regrant got=%b/%h exp=1/304", bus_req_o, bus_addr_o); end
    bus_ready_i = 1; bus_rdata_i = 32'h66;
    @(negedge clk);
    total++; if ({if_ack_o, if_rdata_o} !== {1'b1, 32'h66}) begin bad++; $display("FAIL fl_next_ack got=%b/%h exp=1/66", if_ack_o, if_rdata_o); end
    if_req_i = 0; bus_ready_i = 0;
    @(negedge clk);
    if_req_i = 1; if_flush_i = 1; if_addr_i = 32'h308;
    @(negedge clk);
    total++; if (bus_req_o !== 1'b0) begin bad++; $display("FAIL fl_idle_ignore got=%b exp=0", bus_req_o); end
    if_flush_i = 0;
    @(negedge clk);
    total++; if ({bus_req_o, bus_addr_o} !== {1'b1, 32'h308}) begin bad++; $display("FAIL fl_after_idle got=%b/%h exp=1/308", bus_req_o, bus_addr_o); end
    bus_ready_i = 1; bus_rdata_i = 32'h77;
    @(negedge clk);
    if_req_i = 0; bus_ready_i = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    mem_req_i = 1; mem_we_i = 0; mem_be_i = 4'hF; mem_addr_i = 32'h500;
    @(negedge clk);
    total++; if (bus_req_o !== 1'b1) begin bad++; $display("FAIL rm_busy got=%b exp=1", bus_req_o); end
    @(negedge clk);
    reset_i = 1;
    #1;
    total++; if (bus_req_o !== 1'b0) begin bad++; $display("FAIL rm_async_drop got=%b exp=0", bus_req_o); end
    total++; if ({if_rdata_o, mem_rdata_o} !== 64'h0) begin bad++; $display("FAIL rm_rdata_clr got=%h/%h exp=0/0", if_rdata_o, mem_rdata_o); end
    @(negedge clk);
    reset_i = 0;
    total++; if ({bus_req_o, mem_ack_o} !== 2'b00) begin bad++; $display("FAIL rm_in_reset got=%b exp=00", {bus_req_o, mem_ack_o}); end
    @(negedge clk);
    total++; if ({bus_req_o, mem_ack_o} !== 2'b10) begin bad++; $display("FAIL rm_regrant got=%b exp=10", {bus_req_o, mem_ack_o}); end
    bus_ready_i = 1; bus_rdata_i = 32'h0BADCAFE;
    @(negedge clk);
    total++; if ({mem_ack_o, mem_rdata_o} !== {1'b1, 32'h0BADCAFE}) begin bad++; $display("FAIL rm_ack got=%b/%h exp=1/0badcafe", mem_ack_o, mem_rdata_o); end
    mem_req_i = 0; bus_ready_i = 0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int owner = 0, ack_who = 0, streak = 0;  // owner/ack_who: 0 none, 1 IF, 2 MEM
    bit kill = 0, if_pend = 0, mem_pend = 0, flush, rdy, if_eff;
    logic [31:0] if_a = '0, m_a = '0, m_wd = '0, o_addr = '0, o_wdata = '0;
    logic [31:0] e_if = '0, e_mem = '0;
    logic [3:0]  m_be = '0, o_be = '0;
    logic        m_we = 0, o_we = 0;
    reset_i = 1; idle_inputs();
    @(negedge clk);
    reset_i = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      total++; if (bus_req_o !== (owner != 0)) begin bad++; $display("FAIL rnd_bus_req cyc=%0d got=%b exp=%b", cyc, bus_req_o, owner != 0); end
      if (owner != 0) begin
        total++; if ({bus_addr_o, bus_we_o, bus_be_o} !== {o_addr, o_we, o_be}) begin bad++; $display("FAIL rnd_bus_attr cyc=%0d got=%h/%b/%h exp=%h/%b/%h", cyc, bus_addr_o, bus_we_o, bus_be_o, o_addr, o_we, o_be); end
        if (o_we) begin
          total++; if (bus_wdata_o !== o_wdata) begin bad++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, bus_wdata_o, o_wdata); end
        end
      end
      total++; if ({if_ack_o, mem_ack_o} !== {ack_who == 1, ack_who == 2}) begin bad++; $display("FAIL rnd_acks cyc=%0d got=%b%b exp=%b%b", cyc, if_ack_o, mem_ack_o, ack_who == 1, ack_who == 2); end
      total++; if ({if_rdata_o, mem_rdata_o} !== {e_if, e_mem}) begin bad++; $display("FAIL rnd_rdata cyc=%0d got=%h/%h exp=%h/%h", cyc, if_rdata_o, mem_rdata_o, e_if, e_mem); end

      if (ack_who == 1) if_pend = 0;
      if (ack_who == 2) mem_pend = 0;
      flush = ($urandom_range(0, 15) == 0);
      if (flush) begin if_pend = $urandom_range(0, 1); if_a = 32'h1000 + 32'($urandom_range(0, 15)) * 4; end
      if (!if_pend && $urandom_range(0, 3) == 0) begin if_pend = 1; if_a = 32'h1000 + 32'($urandom_range(0, 15)) * 4; end
      if (!mem_pend && $urandom_range(0, 2) == 0) begin
        mem_pend = 1; m_we = $urandom_range(0, 1); m_be = 4'($urandom_range(1, 15));
        m_a = 32'h1000 + 32'($urandom_range(0, 15)) * 4; m_wd = $urandom;
      end
      rdy = $urandom_range(0, 1);
      if_req_i = if_pend; if_addr_i = if_a; if_flush_i = flush;
      mem_req_i = mem_pend; mem_we_i = m_we; mem_be_i = m_be; mem_addr_i = m_a; mem_wdata_i = m_wd;
      bus_ready_i = rdy; bus_rdata_i = slave_read(bus_addr_o);
      if (rdy && bus_req_o && bus_we_o) slave_mem[bus_addr_o] = merge(slave_read(bus_addr_o), bus_wdata_o, bus_be_o);

      // Predict the effect of the coming edge.
      if (ack_who != 0) ack_who = 0;
      else if (owner != 0) begin
        if (owner == 1 && flush) kill = 1;
        if (rdy) begin
          if (owner == 2) begin
            ack_who = 2;
            if (o_we) ref_mem[o_addr] = merge(ref_read(o_addr), o_wdata, o_be);
            else e_mem = ref_read(o_addr);
          end else if (kill) kill = 0;
          else begin ack_who = 1; e_if = ref_read(o_addr); end
          owner = 0;
        end
      end else begin
        if_eff = if_pend && !flush;
        if (mem_pend && !(streak == MAXS && if_eff)) begin
          owner = 2; o_addr = m_a; o_we = m_we; o_be = m_be; o_wdata = m_wd;
          streak = if_pend ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
        end else if (if_eff) begin
          owner = 1; o_addr = if_a; o_we = 0; o_be = 4'hF; o_wdata = '0;
          streak = 0;
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_store();
    test_simultaneous();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
